// File: rtl/exec_ctrl.sv
// Multi-cycle execution controller: fetches 16-bit instructions, hands operands to an
// external ALU, and writes results back into a four-entry 8-bit register file.
module exec_ctrl (
  input  logic       clk_i,
  input  logic       rst_ni,
  output logic       imem_req_o,
  output logic [7:0] imem_addr_o,
  input  logic       imem_ack_i,
  input  logic [15:0] imem_data_i,
  output logic [3:0] alu_inst_o,
  output logic [7:0] alu_reg1_o,
  output logic [7:0] alu_reg2_o,
  input  logic [7:0] alu_reg_i,
  input  logic       alu_branch_i,
  input  logic       alu_over_flag_i,
  output logic       ovf_o,
  output logic       halt_o
);

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_SFL  = 4'h2;
  localparam logic [3:0] OP_SFR  = 4'h3;
  localparam logic [3:0] OP_INC  = 4'h4;
  localparam logic [3:0] OP_DEC  = 4'h5;
  localparam logic [3:0] OP_BNE  = 4'h6;
  localparam logic [3:0] OP_BEQ  = 4'h7;
  localparam logic [3:0] OP_BLT  = 4'h8;
  localparam logic [3:0] OP_LHB  = 4'h9;
  localparam logic [3:0] OP_JMP  = 4'hA;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic [7:0]  opa_q, opa_d;
  logic [7:0]  opb_q, opb_d;
  logic [7:0]  rf_q [4];
  logic [7:0]  rf_d [4];
  logic [7:0]  res_q, res_d;
  logic        br_q, br_d;
  logic        alu_ovf_q, alu_ovf_d;
  logic        ovf_q, ovf_d;

  logic [3:0] op;
  logic [1:0] rd;
  logic [1:0] rs;
  logic [7:0] imm;
  logic       writes_rd;
  logic       is_branch;

  assign op  = ir_q[15:12];
  assign rd  = ir_q[11:10];
  assign rs  = ir_q[9:8];
  assign imm = ir_q[7:0];

  assign writes_rd = op inside {OP_ADD, OP_SUB, OP_SFL, OP_SFR, OP_INC, OP_DEC, OP_LHB};
  assign is_branch = op inside {OP_BNE, OP_BEQ, OP_BLT, OP_JMP};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      pc_q      <= '0;
      ir_q      <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      res_q     <= '0;
      br_q      <= 1'b0;
      alu_ovf_q <= 1'b0;
      ovf_q     <= 1'b0;
      for (int i = 0; i < 4; i++) rf_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      res_q     <= res_d;
      br_q      <= br_d;
      alu_ovf_q <= alu_ovf_d;
      ovf_q     <= ovf_d;
      rf_q      <= rf_d;
    end
  end

  // ALU response is registered at the end of EXEC so WB never depends on live ALU inputs.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    rf_d      = rf_q;
    res_d     = res_q;
    br_d      = br_q;
    alu_ovf_d = alu_ovf_q;
    ovf_d     = ovf_q;
    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        if (imem_ack_i) begin
          ir_d    = imem_data_i;
          state_d = DECODE;
        end
      end
      DECODE: begin
        opa_d   = (op == OP_LHB) ? imm : rf_q[rd];
        opb_d   = rf_q[rs];
        state_d = EXEC;
      end
      EXEC: begin
        res_d     = alu_reg_i;
        br_d      = alu_branch_i;
        alu_ovf_d = alu_over_flag_i;
        state_d   = WB;
      end
      WB: begin
        if (writes_rd) rf_d[rd] = res_q;
        if (op == OP_ADD) ovf_d = alu_ovf_q;
        if (op == OP_HALT) begin
          state_d = HALT;
        end else begin
          pc_d    = (is_branch && br_q) ? imm : pc_q + 8'd1;
          state_d = FETCH;
        end
      end
      HALT: state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  assign imem_req_o  = (state_q == FETCH);
  assign imem_addr_o = pc_q;
  assign alu_inst_o  = (state_q == EXEC) ? op : 4'h0;
  assign alu_reg1_o  = (state_q == EXEC) ? opa_q : 8'h00;
  assign alu_reg2_o  = (state_q == EXEC) ? opb_q : 8'h00;
  assign ovf_o       = ovf_q;
  assign halt_o      = (state_q == HALT);

endmodule

// File: doc/exec_ctrl.md
EXEC_CTRL -- requirements
Module: exec_ctrl

Interface
REQ-001 SHALL provide one clock and one reset; reset is asynchronous and active-low.
REQ-002 SHALL have ports, clock and reset first:
 clk_i  in  1  rising-edge clock
 rst_ni  in  1  asynchronous active-low reset
 imem_req_o  out  1  instruction fetch request
 imem_addr_o  out  8  fetch address, equal to PC
 imem_ack_i  in  1  fetch acknowledge; imem_data_i is valid in the same cycle
 imem_data_i  in  16  instruction word
 alu_inst_o  out  4  opcode to the ALU
 alu_reg1_o  out  8  ALU operand 1
 alu_reg2_o  out  8  ALU operand 2
 alu_reg_i  in  8  ALU result
 alu_branch_i  in  1  ALU branch-taken
 alu_over_flag_i  in  1  ALU overflow flag
 ovf_o  out  1  overflow flag latched from the last ADD
 halt_o  out  1  core halted
REQ-003 SHALL use this instruction format: [15:12] op, [11:10] rd, [9:8] rs, [7:0] imm.
REQ-004 SHALL use this opcode map: 0000 ADD, 0001 SUB, 0010 SFL, 0011 SFR, 0100 INC, 0101 DEC, 0110 BNE, 0111 BEQ, 1000 BLT, 1001 LHB, 1010 JMP, 1011-1110 NOP, 1111 HALT.

Function
REQ-005 SHALL hold an 8-bit PC, a 16-bit IR, two 8-bit operand registers (opa, opb) and a register file R0-R3, each 8 bits.
REQ-006 SHALL implement the FSM states IDLE, FETCH, DECODE, EXEC, WB and HALT.
REQ-007 SHALL make these transitions: IDLE->FETCH unconditionally; FETCH->DECODE when imem_ack_i=1, otherwise stay in FETCH; DECODE->EXEC; EXEC->WB; WB->FETCH; WB->HALT when op=HALT; HALT is terminal until reset.
REQ-008 SHALL assert imem_req_o only in FETCH, holding it and imem_addr_o stable until ack.
REQ-009 SHALL load IR from imem_data_i on the clock edge where FETCH and ack are both 1, and SHALL ignore ack in all other states.
REQ-010 SHALL, in DECODE, load opa=R[rd] and opb=R[rs], except for LHB where opa=imm.
REQ-011 SHALL drive alu_inst_o=IR[15:12], alu_reg1_o=opa and alu_reg2_o=opb in EXEC.
REQ-012 SHALL drive alu_inst_o, alu_reg1_o and alu_reg2_o to 0 in all states other than EXEC.
REQ-013 SHALL capture alu_reg_i and alu_branch_i into internal registers at the end of EXEC.
REQ-014 SHALL, in WB for ADD/SUB/SFL/SFR/INC/DEC/LHB, write the captured result to R[rd] with all arithmetic modulo 256.
REQ-015 SHALL make no register write in WB for BNE/BEQ/BLT/JMP/NOP/HALT.
REQ-016 SHALL, in WB, set PC=imm when the captured branch=1 and op is BNE/BEQ/BLT/JMP.
REQ-017 SHALL, in WB, set PC=PC+1 (wrapping 0xFF->0x00) in all other cases, except HALT.
REQ-018 SHALL leave PC unchanged on HALT.
REQ-019 SHALL, in WB of ADD, set ovf_o=the captured alu_over_flag_i, and SHALL leave ovf_o unchanged for every other op.
REQ-020 SHALL assert halt_o in HALT and keep imem_req_o=0 there.
REQ-021 SHALL give a best-case latency of 4 clocks per instruction (FETCH with ack in the same cycle, DECODE, EXEC, WB), and SHALL add one cycle per FETCH wait cycle.
REQ-022 SHALL perform a DECODE read of a register in the cycle after its WB write and return the newly written value; no bypass is needed.
REQ-023 SHALL treat rd=rs as legal, with both operands equal to the same register.

Reset
REQ-024 SHALL, while rst_ni=0, force state=IDLE, PC=0, IR=0, opa=opb=0, R0-R3=0, ovf_o=0, halt_o=0, imem_req_o=0, imem_addr_o=0 and ALU outputs=0.
REQ-025 SHALL allow reset asserted in any state, including mid-FETCH with the request outstanding, to abandon the instruction, make no register write, and restart from IDLE with PC=0.
REQ-026 SHALL raise imem_req_o exactly 2 clocks after the rising edge of rst_ni (IDLE, then FETCH).

Verification
REQ-027 SHALL cover: program 9_AB (LHB R0, imm=0xAB) at addr 0 with immediate ack -> R0=0xA0, PC=1, imem_req_o high again 4 clocks after the first ack.
REQ-028 SHALL cover: R0=0xF0, R1=0x20, ADD R0,R1 -> R0=0x10, alu_over_flag_i=1, ovf_o=1.
REQ-029 SHALL cover: R0=R1=5, BEQ R0,R1 imm=0x40 -> PC=0x40; BNE with the same operands -> PC=old+1.
REQ-030 SHALL cover: ack withheld 3 cycles -> imem_req_o and imem_addr_o held constant, instruction completes in 7 clocks, and no IR change before ack.
REQ-031 SHALL cover: PC=0xFF executing a NOP -> PC wraps to 0x00; HALT at addr 0 -> halt_o=1, imem_req_o stays 0 for 20 cycles.
REQ-032 SHALL cover: rst_ni pulled low mid-EXEC of an INC -> target register stays 0, PC=0, state restarts at IDLE.
